snake_turn_scheduler: RTL



---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_turn_fifo.sv | 66 ++++++
 rtl/snake_turn_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake datapath: directions, game states and IR command codes.
// Direction ordering must match the movement logic's STATE_LEFT..STATE_UP.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } game_state_e;

  localparam logic [7:0] IrLeft  = 8'h44;
  localparam logic [7:0] IrRight = 8'h43;
  localparam logic [7:0] IrUp    = 8'h46;
  localparam logic [7:0] IrDown  = 8'h15;

  // Opposite pairs differ only in bit 0 (LEFT/RIGHT, DOWN/UP).
  function automatic dir_e dir_opposite(dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// Two-entry turn queue; head is entry 0, tail is the most recently pushed entry.
module snake_turn_fifo
  import snake_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  dir_e       data_i,
  output dir_e       head_o,
  output dir_e       tail_o,
  output logic [1:0] count_o
);

  dir_e       mem_q [2];
  dir_e       mem_d [2];
  logic [1:0] count_q, count_d;
  logic       do_pop, do_push;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    count_d  = count_q;
    do_pop   = pop_i && (count_q != 2'd0);
    // A full queue still accepts a push when an entry leaves in the same cycle.
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    if (flush_i) begin
      count_d = 2'd0;
    end else if (do_pop && do_push) begin
      if (count_q == 2'd2) begin
        mem_d[0] = mem_q[1];
        mem_d[1] = data_i;
      end else begin
        mem_d[0] = data_i;
      end
    end else if (do_pop) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - 2'd1;
    end else if (do_push) begin
      if (count_q == 2'd0) begin
        mem_d[0] = data_i;
      end else begin
        mem_d[1] = data_i;
      end
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= DIR_RIGHT;
      mem_q[1] <= DIR_RIGHT;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[0];
  assign tail_o  = (count_q == 2'd2) ? mem_q[1] : mem_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/snake_turn_scheduler.sv
// Move tick, direction arbitration, turn queue and game-level sequencing for the snake.
// Define SNAKE_SPEEDUP_EN to make the move period shrink as food is eaten.
module snake_turn_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned TICK_BASE = 12500000,
  parameter int unsigned TICK_STEP = 600000,
  parameter int unsigned TICK_MIN  = 3000000,
  parameter int unsigned MAX_LVL   = 15,
  parameter logic [7:0]  IR_PAUSE  = 8'h40
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [7:0] ir_code,
  input  logic       ir_valid,
  input  logic       die_in,
  input  logic       eat_in,
  output logic       move_en,
  output logic [1:0] dir,
  output logic [1:0] game_state,
  output logic [3:0] speed_lvl,
  output logic [1:0] q_count
);

  game_state_e state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d, period_calc;
  logic [3:0]  lvl_q, lvl_d;
  logic [3:0]  key_q, fall;
  logic        req_valid, ir_pause, wrap, push_ok;
  logic        fifo_push, fifo_pop, fifo_flush;
  dir_e        req_dir, ref_dir, fifo_head, fifo_tail;
  logic [1:0]  fifo_count;

`ifdef SNAKE_SPEEDUP_EN
  logic [31:0] reduce, base;
  always_comb begin
    reduce      = 32'(lvl_q) * TICK_STEP;
    base        = (TICK_BASE > reduce) ? (TICK_BASE - reduce) : 32'd0;
    period_calc = (base < TICK_MIN) ? TICK_MIN : base;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg  = TICK_STEP ^ TICK_MIN ^ MAX_LVL ^ {31'd0, eat_in};
  assign period_calc = TICK_BASE;
`endif

  // Key beats IR; among keys UP > DOWN > LEFT > RIGHT.
  always_comb begin
    fall      = key_q & ~{key_up, key_down, key_left, key_right};
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (fall[3]) begin
      req_dir = DIR_UP;
    end else if (fall[2]) begin
      req_dir = DIR_DOWN;
    end else if (fall[1]) begin
      req_dir = DIR_LEFT;
    end else if (fall[0]) begin
      req_dir = DIR_RIGHT;
    end else if (ir_valid) begin
      case (ir_code)
        IrLeft:  req_dir = DIR_LEFT;
        IrRight: req_dir = DIR_RIGHT;
        IrUp:    req_dir = DIR_UP;
        IrDown:  req_dir = DIR_DOWN;
        default: req_valid = 1'b0;
      endcase
    end else begin
      req_valid = 1'b0;
    end
  end

  assign ir_pause = ir_valid && (ir_code == IR_PAUSE);
  assign wrap     = (cnt_q == (period_q - 32'd1));
  assign ref_dir  = (fifo_count != 2'd0) ? fifo_tail : dir_q;
  assign push_ok  = req_valid && (req_dir != ref_dir) && (req_dir != dir_opposite(ref_dir));

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    lvl_d      = lvl_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    move_en    = (state_q == StRun) && wrap;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          dir_d    = req_dir;
          cnt_d    = 32'd0;
          period_d = period_calc;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (die_in) begin
          state_d = StOver;
        end else begin
          fifo_push = push_ok;
          if (wrap) begin
            // Period is re-latched only here so speed changes apply from the next period.
            cnt_d    = 32'd0;
            period_d = period_calc;
            if (fifo_count != 2'd0) begin
              fifo_pop = 1'b1;
              dir_d    = fifo_head;
            end
          end else if (!ir_pause) begin
            cnt_d = cnt_q + 32'd1;
          end
          if (ir_pause) begin
            state_d = StPause;
          end
`ifdef SNAKE_SPEEDUP_EN
          if (eat_in && (32'(lvl_q) < MAX_LVL)) begin
            lvl_d = lvl_q + 4'd1;
          end
`endif
        end
      end
      StPause: begin
        if (die_in) begin
          state_d = StOver;
        end else if (ir_pause) begin
          state_d = StRun;
        end
      end
      StOver: begin
        if (req_valid) begin
          state_d    = StIdle;
          lvl_d      = 4'd0;
          fifo_flush = 1'b1;
          dir_d      = DIR_RIGHT;
          cnt_d      = 32'd0;
          period_d   = TICK_BASE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      dir_q    <= DIR_RIGHT;
      cnt_q    <= 32'd0;
      period_q <= TICK_BASE;
      lvl_q    <= 4'd0;
      key_q    <= 4'hf;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      lvl_q    <= lvl_d;
      key_q    <= {key_up, key_down, key_left, key_right};
    end
  end

  snake_turn_fifo u_turn_fifo (
    .clk_i   (vga_clk),
    .rst_ni  (sys_rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (req_dir),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail),
    .count_o (fifo_count)
  );

  assign dir        = dir_q;
  assign game_state = state_q;
  assign speed_lvl  = lvl_q;
  assign q_count    = fifo_count;

endmodule
